fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Drain-side companion to the 32x8 synchronous FIFO. It pops bytes through the FIFO's `rd`/`empty` port and absorbs the FIFO's one-cycle registered read latency. It re-presents the data as a valid/ready stream with burst framing (`m_last`) and a running beat counter. It sits between the FIFO and any downstream consumer and sustains one beat per clock under continuous `m_ready`.

## Interface
- `DATA_W`, default 8: data width; must match the FIFO width.
- `BURST_LEN`, default 4: beats per burst; `m_last` marks every `BURST_LEN`-th beat; legal values are 1 or more.
- `CNT_W`, default 16: width of `beat_count`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  allows new FIFO pops; in-flight data still drains when low.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_rd`  out  1  FIFO `rd` strobe (combinational).
- `fifo_data`  in  DATA_W  FIFO `data_out`; valid in the cycle after a `fifo_rd` cycle.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  consumer accepts the beat.
- `m_data`  out  DATA_W  stream data.
- `m_last`  out  1  final beat of a burst.
- `beat_count`  out  CNT_W  total accepted beats, modulo 2^CNT_W.

## Operation
- State:
  - 3-entry circular buffer with head/tail indices modulo 3 and `occ` (0..3).
  - `pending` flag: a pop was issued last cycle.
  - `burst_cnt` (0..BURST_LEN-1).
  - `beat_count`.
- `fifo_rd = enable & ~fifo_empty & (occ + pending < 3)`. It depends only on registered state and inputs, and has no path from `m_ready`.
- `pending` is set to `fifo_rd` every cycle.
- When `pending` is 1, `fifo_data` is written at the tail, and the tail advances.
- `m_valid = (occ != 0)`; `m_data = buf[head]`.
- On a handshake (`m_valid & m_ready`):
  - head advances;
  - `beat_count` increments, wrapping at 2^CNT_W;
  - `burst_cnt` increments, wrapping to 0 after BURST_LEN-1.
- `m_last = m_valid & (burst_cnt == BURST_LEN-1)`. With BURST_LEN=1, `m_last` equals `m_valid`.
- Capture and handshake in the same cycle: `occ` is unchanged, and head and tail both advance.
- The credit rule guarantees no overflow: a capture never occurs when `occ` is 3 without a simultaneous pop.
- `enable` falling: no new `fifo_rd`; any pending byte is still captured; the buffer drains normally. `burst_cnt` is preserved across `enable` gaps.
- `fifo_empty` high: no pop; the stream stalls with `m_valid` low once the buffer drains. `burst_cnt` is not reset.
- `m_valid` holds once asserted until the handshake, and `m_data` stays stable while `m_valid & ~m_ready` (AXI-stream rule).

## Timing
- Reset (`rst_n` low, asynchronous): `occ`=0, `pending`=0, head/tail=0, `burst_cnt`=0, `beat_count`=0. Hence `m_valid`=0, `m_last`=0, `m_data`=buf[0]; the buffer contents are don't-care.
- `fifo_rd` is 0 while in reset.
- Reset mid-stream: buffered and in-flight bytes are discarded. The FIFO is reset by its own reset; system reset drives both.
- Latency:
  - `fifo_rd` in cycle N → `fifo_data` valid in cycle N+1 → captured at the end of N+1 → `m_valid` high in cycle N+2.
- Throughput: 1 beat/cycle sustained with `m_ready`=1 and a non-empty FIFO (steady state `occ`=1, `pending`=1).
- Backpressure: with `m_ready`=0, at most 3 pops are issued before `fifo_rd` stops.
- Deassertion of `rst_n` is synchronised externally. The block takes no action in the first cycle beyond holding its reset values.

## Structure
- Package `fifo_stream_reader_pkg`:
  - constant `RD_BUF_DEPTH = 3`;
  - typedef `occ_t` (2 bits);
  - typedef `idx_t` (2 bits, mod-3 index);
  - function `idx_inc` (wraps 2→0).
- Sub-module `fifo_stream_reader_buf`: the 3-entry storage with head/tail/`occ`, with ports push, pop, `din`, `dout`, `occ`. Framing, counters and credit logic stay in the top.

## Test plan
- Reset: hold `rst_n`=0 with `fifo_empty`=0 and `enable`=1 → `fifo_rd`=0, `m_valid`=0, `m_last`=0, `beat_count`=0. Asserting `rst_n`=0 asynchronously mid-cycle clears `m_valid` immediately.
- Streaming: preload 0x10..0x17, `m_ready`=1 → `fifo_rd` high 8 consecutive cycles; `m_data` 0x10..0x17 on 8 consecutive cycles starting 2 cycles after the first `fifo_rd`; `m_last` on 0x13 and 0x17; `beat_count`=8.
- Backpressure: preload 5 bytes 0xA0..0xA4, `m_ready`=0 → exactly 3 `fifo_rd` pulses; `m_data` holds 0xA0. Release `m_ready` → 0xA0..0xA4 in order, no loss or duplication; `m_last` on 0xA3.
- Empty/trickle: FIFO empty → no `fifo_rd`. Write a single byte 0x55 → one `fifo_rd`, then `m_valid` for exactly one beat of 0x55.
- Enable gap: drop `enable` after the 2nd pop of 8 bytes → the in-flight byte is still delivered. Re-enable → the remaining bytes follow; `m_last` still lands on the 4th and 8th beats.
- Counter wrap (CNT_W=4): 17 beats → `beat_count` reads 1.

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants, index types and the mod-3 index helper for the
// FIFO stream reader's small elastic buffer.
package fifo_stream_reader_pkg;

    localparam int RD_BUF_DEPTH = 3;

    typedef logic [1:0] occ_t;
    typedef logic [1:0] idx_t;

    // Indices count 0,1,2 and then wrap back to 0.
    function automatic idx_t idx_inc(input idx_t idx);
        return (idx == idx_t'(RD_BUF_DEPTH - 1)) ? idx_t'(0) : idx + idx_t'(1);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_buf.sv
// Three-entry circular buffer that soaks up the FIFO read latency so the
// stream side can keep one beat per clock while still honouring backpressure.
module fifo_stream_reader_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output occ_t              occ
);

    logic [DATA_W-1:0] mem_q [RD_BUF_DEPTH];
    idx_t              head_q, head_d;
    idx_t              tail_q, tail_d;
    occ_t              occ_q, occ_d;

    always_comb begin
        head_d = pop  ? idx_inc(head_q) : head_q;
        tail_d = push ? idx_inc(tail_q) : tail_q;
        occ_d  = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + occ_t'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - occ_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Payload storage carries no reset; its contents only matter once occ says so.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= din;
        end
    end

    assign dout = mem_q[head_q];
    assign occ  = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO with one-cycle read latency and re-presents the
// bytes as a valid/ready stream with burst framing and a running beat count.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [CNT_W-1:0]  beat_count
);

    localparam int            BW         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

    occ_t             occ;
    logic             pending_q;
    logic             handshake;
    logic [2:0]       credit_used;
    logic [BW-1:0]    burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    // A pop in flight already owns a buffer slot, so it counts against the credit.
    assign credit_used = {1'b0, occ} + {2'b00, pending_q};
    assign fifo_rd     = rst_n & enable & ~fifo_empty & (credit_used < 3'(RD_BUF_DEPTH));

    assign m_valid     = (occ != '0);
    assign handshake   = m_valid & m_ready;
    assign m_last      = m_valid & (burst_cnt_q == BURST_LAST);
    assign beat_count  = beat_cnt_q;

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        if (handshake) begin
            beat_cnt_d  = beat_cnt_q + CNT_W'(1);
            burst_cnt_d = (burst_cnt_q == BURST_LAST) ? '0 : burst_cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= 1'b0;
            burst_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            pending_q   <= fifo_rd;
            burst_cnt_q <= burst_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    fifo_stream_reader_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pending_q),
        .pop   (handshake),
        .din   (fifo_data),
        .dout  (m_data),
        .occ   (occ)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO model feeds the DUT and an
// in-order byte scoreboard with beat-index framing predicts the stream.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int BL = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          fifo_empty;
    logic          fifo_rd;
    logic [DW-1:0] fifo_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [CW-1:0] beat_count;

    int nChecks = 0;
    int nPass   = 0;

    logic [7:0] fifoQ[$];
    logic [7:0] expQ[$];
    int         acc;

    logic          obsRd, obsValid, obsReady, obsLast, obsEnable;
    logic [DW-1:0] obsData;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_W    (DW),
        .BURST_LEN (BL),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .beat_count (beat_count)
    );

    // Samples the cycle's outputs, then advances one clock and plays the FIFO read.
    task automatic step();
        #1;
        obsRd     = fifo_rd;
        obsValid  = m_valid;
        obsReady  = m_ready;
        obsLast   = m_last;
        obsData   = m_data;
        obsEnable = enable;
        @(posedge clk);
        #1;
        if (obsRd) begin
            if (fifoQ.size() > 0) fifo_data = fifoQ.pop_front();
            else fifo_data = 8'($urandom);
        end
        fifo_empty = (fifoQ.size() == 0);
    endtask

    task automatic pushByte(input logic [7:0] b);
        fifoQ.push_back(b);
        expQ.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic doReset();
        rst_n      = 1'b0;
        enable     = 1'b1;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = 8'($urandom);
        fifoQ.delete();
        expQ.delete();
        acc = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        enable     = 1'b1;
        fifo_empty = 1'b0;
        m_ready    = 1'b1;
        fifo_data  = 8'h3c;
        repeat (3) @(posedge clk);
        #2;
        nChecks++;
        if (fifo_rd !== 1'b0) $display("[TB] FAIL reset_rd: got %b expected 0", fifo_rd);
        else nPass++;
        nChecks++;
        if (m_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", m_valid);
        else nPass++;
        nChecks++;
        if (m_last !== 1'b0) $display("[TB] FAIL reset_last: got %b expected 0", m_last);
        else nPass++;
        nChecks++;
        if (beat_count !== 4'd0) $display("[TB] FAIL reset_count: got %0d expected 0", beat_count);
        else nPass++;
    endtask

    task automatic test_streaming();
        int firstRd, lastRd, nRd, firstBeat, lastBeat, nBeat;
        doReset();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) pushByte(8'h10 + 8'(i));
        firstRd = -1; lastRd = -1; nRd = 0; firstBeat = -1; lastBeat = -1; nBeat = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (obsRd) begin
                if (firstRd < 0) firstRd = k;
                lastRd = k;
                nRd++;
            end
            if (obsValid && obsReady) begin
                if (firstBeat < 0) firstBeat = k;
                lastBeat = k;
                nBeat++;
                nChecks++;
                if (expQ.size() == 0) $display("[TB] FAIL stream_extra: got %0h expected none", obsData);
                else if (obsData !== expQ[0] || obsLast !== ((acc % BL) == BL - 1))
                    $display("[TB] FAIL stream_beat: got %0h/%b expected %0h/%b",
                             obsData, obsLast, expQ[0], (acc % BL) == BL - 1);
                else nPass++;
                if (expQ.size() > 0) void'(expQ.pop_front());
                acc++;
            end
        end
        nChecks++;
        if (nRd != 8 || lastRd - firstRd != 7)
            $display("[TB] FAIL stream_rd_run: got %0d pops over %0d cycles expected 8 over 8", nRd, lastRd - firstRd + 1);
        else nPass++;
        nChecks++;
        if (firstBeat != firstRd + 2) $display("[TB] FAIL stream_latency: got %0d expected %0d", firstBeat, firstRd + 2);
        else nPass++;
        nChecks++;
        if (nBeat != 8 || lastBeat - firstBeat != 7)
            $display("[TB] FAIL stream_beat_run: got %0d beats over %0d cycles expected 8 over 8", nBeat, lastBeat - firstBeat + 1);
        else nPass++;
        nChecks++;
        if (beat_count !== 4'(acc)) $display("[TB] FAIL stream_count: got %0d expected %0d", beat_count, acc % 16);
        else nPass++;
    endtask

    task automatic test_backpressure();
        int nRd, holdErr;
        doReset();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) pushByte(8'ha0 + 8'(i));
        nRd = 0; holdErr = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (obsRd) nRd++;
            if (obsValid && obsData !== 8'ha0) holdErr++;
        end
        nChecks++;
        if (nRd != 3) $display("[TB] FAIL bp_pops: got %0d expected 3", nRd);
        else nPass++;
        nChecks++;
        if (holdErr != 0 || !obsValid) $display("[TB] FAIL bp_hold: got %0d bad cycles valid=%b expected 0 and 1", holdErr, obsValid);
        else nPass++;
        m_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (obsValid && obsReady) begin
                nChecks++;
                if (expQ.size() == 0) $display("[TB] FAIL bp_extra: got %0h expected none", obsData);
                else if (obsData !== expQ[0] || obsLast !== ((acc % BL) == BL - 1))
                    $display("[TB] FAIL bp_beat: got %0h/%b expected %0h/%b",
                             obsData, obsLast, expQ[0], (acc % BL) == BL - 1);
                else nPass++;
                if (expQ.size() > 0) void'(expQ.pop_front());
                acc++;
            end
        end
        nChecks++;
        if (acc != 5 || expQ.size() != 0) $display("[TB] FAIL bp_total: got %0d beats expected 5", acc);
        else nPass++;
    endtask

    task automatic test_trickle();
        int nRd, nValid;
        doReset();
        m_ready = 1'b1;
        nRd = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (obsRd) nRd++;
        end
        nChecks++;
        if (nRd != 0) $display("[TB] FAIL empty_rd: got %0d pops expected 0", nRd);
        else nPass++;
        pushByte(8'h55);
        nRd = 0; nValid = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (obsRd) nRd++;
            if (obsValid) begin
                nValid++;
                nChecks++;
                if (obsData !== 8'h55 || obsLast !== 1'b0)
                    $display("[TB] FAIL trickle_beat: got %0h/%b expected 55/0", obsData, obsLast);
                else nPass++;
            end
        end
        nChecks++;
        if (nRd != 1 || nValid != 1) $display("[TB] FAIL trickle_count: got %0d pops %0d beats expected 1 and 1", nRd, nValid);
        else nPass++;
    endtask

    task automatic test_enable_gap();
        int pops, gapCyc, gapRd, gapBeats;
        logic gapDone;
        doReset();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) pushByte(8'h20 + 8'(i));
        pops = 0; gapCyc = 0; gapRd = 0; gapBeats = 0; gapDone = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (obsRd) pops++;
            if (!obsEnable && obsRd) gapRd++;
            if (obsValid && obsReady) begin
                if (!obsEnable) gapBeats++;
                nChecks++;
                if (expQ.size() == 0) $display("[TB] FAIL gap_extra: got %0h expected none", obsData);
                else if (obsData !== expQ[0] || obsLast !== ((acc % BL) == BL - 1))
                    $display("[TB] FAIL gap_beat: got %0h/%b expected %0h/%b",
                             obsData, obsLast, expQ[0], (acc % BL) == BL - 1);
                else nPass++;
                if (expQ.size() > 0) void'(expQ.pop_front());
                acc++;
            end
            if (enable && pops == 2 && !gapDone) begin
                enable = 1'b0;
            end else if (!enable) begin
                gapCyc++;
                if (gapCyc == 5) begin
                    enable  = 1'b1;
                    gapDone = 1'b1;
                end
            end
        end
        nChecks++;
        if (gapRd != 0) $display("[TB] FAIL gap_rd: got %0d pops while disabled expected 0", gapRd);
        else nPass++;
        nChecks++;
        if (gapBeats != 2) $display("[TB] FAIL gap_drain: got %0d beats while disabled expected 2", gapBeats);
        else nPass++;
        nChecks++;
        if (acc != 8) $display("[TB] FAIL gap_total: got %0d beats expected 8", acc);
        else nPass++;
    endtask

    task automatic test_random();
        int pops, stallErr, creditErr;
        logic prevStall;
        logic [7:0] prevData;
        doReset();
        pops = 0; stallErr = 0; creditErr = 0; prevStall = 1'b0; prevData = '0;
        for (int k = 0; k < 460; k++) begin
            if (k < 400) begin
                m_ready = ($urandom_range(3) != 0);
                enable  = ($urandom_range(9) != 0);
                if ($urandom_range(4) < 2 && fifoQ.size() < 32) pushByte(8'($urandom));
            end else begin
                m_ready = 1'b1;
                enable  = 1'b1;
            end
            step();
            if (obsRd) pops++;
            if (prevStall && (!obsValid || obsData !== prevData)) stallErr++;
            if (obsValid && obsReady) begin
                nChecks++;
                if (expQ.size() == 0) $display("[TB] FAIL rand_extra: got %0h expected none", obsData);
                else if (obsData !== expQ[0] || obsLast !== ((acc % BL) == BL - 1))
                    $display("[TB] FAIL rand_beat: got %0h/%b expected %0h/%b",
                             obsData, obsLast, expQ[0], (acc % BL) == BL - 1);
                else nPass++;
                if (expQ.size() > 0) void'(expQ.pop_front());
                acc++;
            end
            if (pops - acc > 3) creditErr++;
            prevStall = obsValid && !obsReady;
            prevData  = obsData;
        end
        nChecks++;
        if (stallErr != 0) $display("[TB] FAIL rand_stable: got %0d unstable stalls expected 0", stallErr);
        else nPass++;
        nChecks++;
        if (creditErr != 0) $display("[TB] FAIL rand_credit: got %0d overcommits expected 0", creditErr);
        else nPass++;
        nChecks++;
        if (expQ.size() != 0) $display("[TB] FAIL rand_drain: got %0d undelivered expected 0", expQ.size());
        else nPass++;
        nChecks++;
        if (beat_count !== 4'(acc)) $display("[TB] FAIL rand_count: got %0d expected %0d", beat_count, acc % 16);
        else nPass++;
    endtask

    task automatic test_wrap();
        doReset();
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) pushByte(8'($urandom));
        for (int k = 0; k < 25; k++) begin
            step();
            if (obsValid && obsReady) begin
                if (expQ.size() > 0) void'(expQ.pop_front());
                acc++;
            end
        end
        nChecks++;
        if (acc != 17 || beat_count !== 4'd1)
            $display("[TB] FAIL wrap_count: got %0d after %0d beats expected 1 after 17", beat_count, acc);
        else nPass++;
    endtask

    task automatic test_async_reset();
        doReset();
        m_ready = 1'b0;
        pushByte(8'h77);
        pushByte(8'h78);
        for (int k = 0; k < 4; k++) step();
        nChecks++;
        if (m_valid !== 1'b1) $display("[TB] FAIL arst_pre_valid: got %b expected 1", m_valid);
        else nPass++;
        #3;
        rst_n = 1'b0;
        #1;
        nChecks++;
        if (m_valid !== 1'b0 || fifo_rd !== 1'b0)
            $display("[TB] FAIL arst_valid: got valid=%b rd=%b expected 0 and 0", m_valid, fifo_rd);
        else nPass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        fifo_empty = 1'b1;
        m_ready    = 1'b0;
        fifo_data  = '0;
        acc        = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_trickle();
        test_enable_gap();
        test_random();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
